pio_irq_bank: RTL

PIO_IRQ_BANK -- requirements
Module: pio_irq_bank

---
 rtl/pio_pkg.sv | 18 +
 rtl/pio_debounce.sv | 58 +++++
 rtl/pio_irq_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the PIO interrupt bank: bus width and register offsets.
package pio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_DATA_IN  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_DATA_OUT = 3'd1;
  localparam logic [ADDR_W-1:0] REG_SET      = 3'd2;
  localparam logic [ADDR_W-1:0] REG_CLR      = 3'd3;
  localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd4;
  localparam logic [ADDR_W-1:0] REG_EDGE_CAP = 3'd5;
  localparam logic [ADDR_W-1:0] REG_RISE_EN  = 3'd6;
  localparam logic [ADDR_W-1:0] REG_FALL_EN  = 3'd7;

  typedef logic [BUS_W-1:0] bus_word_t;

endpackage

// File: rtl/pio_debounce.sv
// One-bit two-flop synchronizer followed by a hold-steady debouncer.
// rise_c_o/fall_c_o pulse combinationally on the cycle the stable value is loaded.
module pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic stable_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;

  // Count consecutive cycles of disagreement; accept on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept_c = 1'b1;
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= RESET_VAL;
      sync_q   <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      meta_q   <= din_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_c_o = accept_c &  sync_q;
  assign fall_c_o = accept_c & ~sync_q;

endmodule

// File: rtl/pio_irq_bank.sv
// GPIO bank with debounced inputs, set/clear outputs and edge-capture interrupt,
// exposed through an 8-word register slave with one-cycle registered reads.
module pio_irq_bank
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 14,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IN_RESET        = '0,
  parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [BUS_W-1:0]  avs_writedata,
  output logic [BUS_W-1:0]  avs_readdata,
  input  logic [WIDTH-1:0]  pio_in,
  output logic [WIDTH-1:0]  pio_out,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (IN_RESET[gi])
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .din_i   (pio_in[gi]),
      .stable_o(stable[gi]),
      .rise_c_o(rise_c[gi]),
      .fall_c_o(fall_c[gi])
    );
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic             irq_q, irq_d;
  bus_word_t        rdata_q, rdata_d;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] rsel_c;
  logic             unused_wdata;

  assign wdata_c      = avs_writedata[WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  // Register writes, edge capture (new edge beats W1C), irq and read mux.
  always_comb begin
    out_d     = out_q;
    mask_d    = mask_q;
    cap_d     = cap_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    rsel_c    = '0;
    rdata_d   = rdata_q;

    if (avs_write) begin
      case (avs_address)
        REG_DATA_OUT: out_d     = wdata_c;
        REG_SET:      out_d     = out_q | wdata_c;
        REG_CLR:      out_d     = out_q & ~wdata_c;
        REG_IRQ_MASK: mask_d    = wdata_c;
        REG_EDGE_CAP: cap_d     = cap_q & ~wdata_c;
        REG_RISE_EN:  rise_en_d = wdata_c;
        REG_FALL_EN:  fall_en_d = wdata_c;
        default: ;
      endcase
    end
    cap_d = cap_d | (rise_c & rise_en_q) | (fall_c & fall_en_q);

    irq_d = |(cap_q & mask_q);

    case (avs_address)
      REG_DATA_IN:  rsel_c = stable;
      REG_DATA_OUT: rsel_c = out_q;
      REG_IRQ_MASK: rsel_c = mask_q;
      REG_EDGE_CAP: rsel_c = cap_q;
      REG_RISE_EN:  rsel_c = rise_en_q;
      REG_FALL_EN:  rsel_c = fall_en_q;
      default:      rsel_c = '0;
    endcase
    if (avs_read && !avs_write) begin
      rdata_d = BUS_W'(rsel_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= OUT_RESET;
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pio_out      = out_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

endmodule
